logisim_demo_top: RTL and testbench

//   Demo pattern generator for a TinyTapeout-style 8-in/8-out tile.

---
 rtl/logisim_demo_top.sv | 196 +++++++++++++++++++
 tb/tb_logisim_demo_top.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logisim_demo_top.sv
// -----------------------------------------------------------------------------
// logisim_demo_top
//
// Demo pattern generator for an 8-in/8-out tile. Four free-running 8-bit
// generators advance together on every prescaler tick:
//   - binary counter (up or down)
//   - Gray code, derived combinationally from the counter
//   - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1 (optional, see below)
//   - bouncing one-hot dot, period 14
// A pin-selected mode picks the generator shown on io_out. The output is a
// pure combinational mux of registered state, so it adds no latency and
// switching modes never disturbs any generator.
//
// Ports
//   io_in[0]    clock, rising edge
//   io_in[1]    asynchronous active-low reset
//   io_in[3:2]  mode: 00 count, 01 Gray, 10 LFSR, 11 bouncing dot
//   io_in[4]    hold: 1 freezes every register, prescaler included
//   io_in[5]    dir:  1 makes the binary counter count down
//   io_in[7:6]  prescale: 00 /1, 01 /2, 10 /4, 11 /8
//   io_out      selected pattern
//   vccd1/vssd1 power pins, present only in gate-level builds (GL_TEST)
//
// Configuration
//   LOGISIM_DEMO_LFSR_EN  defined: LFSR register is built and shown in mode 10.
//                         undefined: no LFSR flops; mode 10 shows the counter.
// -----------------------------------------------------------------------------
module logisim_demo_top (
`ifdef GL_TEST
   inout  wire        vccd1,
   inout  wire        vssd1,
`endif
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   // ---------------------------------------------------------------------------
   // Pin decode
   // ---------------------------------------------------------------------------
   localparam logic [1:0] MODE_COUNT = 2'b00;
   localparam logic [1:0] MODE_GRAY  = 2'b01;
   localparam logic [1:0] MODE_LFSR  = 2'b10;
   localparam logic [1:0] MODE_DOT   = 2'b11;

   // Direction of travel of the bouncing dot.
   localparam logic [0:0] DOT_LEFT  = 1'b0;
   localparam logic [0:0] DOT_RIGHT = 1'b1;

   logic       w_clk;
   logic       w_rst_n;
   logic [1:0] w_mode;
   logic       w_hold;
   logic       w_dir_down;
   logic [1:0] w_prescale;

   assign w_clk      = io_in[0];
   assign w_rst_n    = io_in[1];
   assign w_mode     = io_in[3:2];
   assign w_hold     = io_in[4];
   assign w_dir_down = io_in[5];
   assign w_prescale = io_in[7:6];

   // ---------------------------------------------------------------------------
   // Prescaler
   // ---------------------------------------------------------------------------
   logic [2:0] r_presc;
   logic [2:0] w_mask;
   logic       w_tick;

   // NOTE: every signal assigned in an always_comb gets a default on entry so
   // that no path leaves it unassigned, which would infer a latch.
   always_comb begin
      w_mask = 3'b000;
      case (w_prescale)
         2'b00:   w_mask = 3'b000;
         2'b01:   w_mask = 3'b001;
         2'b10:   w_mask = 3'b011;
         default: w_mask = 3'b111;
      endcase
   end

   // Tick when the low prescaler bits selected by the mask are all ones. With
   // mask 0 this is every clock. Hold suppresses the tick and also freezes the
   // prescaler below, so the tick phase survives a hold.
   assign w_tick = ((r_presc & w_mask) == w_mask) && !w_hold;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_presc <= 3'd0;
      end else if (!w_hold) begin
         r_presc <= r_presc + 3'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Binary counter (Gray code is derived from it at the output)
   // ---------------------------------------------------------------------------
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;

   // 8-bit arithmetic wraps naturally: 0xFF+1 -> 0x00, 0x00-1 -> 0xFF.
   assign w_cnt_nxt = w_dir_down ? (r_cnt - 8'd1) : (r_cnt + 8'd1);

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_cnt <= 8'h00;
      end else if (w_tick) begin
         r_cnt <= w_cnt_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // LFSR
   // ---------------------------------------------------------------------------
`ifdef LOGISIM_DEMO_LFSR_EN
   logic [7:0] r_lfsr;
   logic       w_lfsr_fb;

   // Maximal-length taps; seeded non-zero at reset, so it never locks at 0x00.
   assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_lfsr <= 8'h01;
      end else if (w_tick) begin
         r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Bouncing dot
   // ---------------------------------------------------------------------------
   logic [7:0] r_dot;
   logic [0:0] r_dot_dir;
   logic [7:0] w_dot_nxt;
   logic [0:0] w_dot_dir_nxt;

   // The turn-around happens in the same step that reaches the end bit, so the
   // next value already moves back: 0x80 -> 0x40 and 0x01 -> 0x02. No value is
   // ever repeated and the full cycle is 14 ticks.
   always_comb begin
      w_dot_nxt     = r_dot;
      w_dot_dir_nxt = r_dot_dir;
      if (r_dot_dir == DOT_LEFT) begin
         if (r_dot[7]) begin
            w_dot_nxt     = {1'b0, r_dot[7:1]};
            w_dot_dir_nxt = DOT_RIGHT;
         end else begin
            w_dot_nxt     = {r_dot[6:0], 1'b0};
         end
      end else begin
         if (r_dot[0]) begin
            w_dot_nxt     = {r_dot[6:0], 1'b0};
            w_dot_dir_nxt = DOT_LEFT;
         end else begin
            w_dot_nxt     = {1'b0, r_dot[7:1]};
         end
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_dot     <= 8'h01;
         r_dot_dir <= DOT_LEFT;
      end else if (w_tick) begin
         r_dot     <= w_dot_nxt;
         r_dot_dir <= w_dot_dir_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Output mux: combinational over registered state only.
   // ---------------------------------------------------------------------------
   logic [7:0] w_gray;

   assign w_gray = r_cnt ^ {1'b0, r_cnt[7:1]};

   always_comb begin
      io_out = r_cnt;
      case (w_mode)
         MODE_COUNT: io_out = r_cnt;
         MODE_GRAY:  io_out = w_gray;
`ifdef LOGISIM_DEMO_LFSR_EN
         MODE_LFSR:  io_out = r_lfsr;
`else
         MODE_LFSR:  io_out = r_cnt;
`endif
         MODE_DOT:   io_out = r_dot;
         default:    io_out = r_cnt;
      endcase
   end

endmodule

// File: tb/tb_logisim_demo_top.sv
// -----------------------------------------------------------------------------
// tb_logisim_demo_top
//
// Scoreboard bench for logisim_demo_top. The stimulus process drives the pins
// on the falling clock edge, advances a reference model that describes the
// generators as positions in their sequences (tick counter, counter value,
// dot phase 0..13), and queues the value io_out must show after the next
// rising edge. A monitor pops and compares one expectation after every rising
// clock edge and after every asynchronous reset assertion.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_logisim_demo_top;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mode  = 2'b00;
   logic       hold  = 1'b0;
   logic       dir   = 1'b0;
   logic [1:0] presc = 2'b00;
   logic [7:0] io_in;
   logic [7:0] io_out;

   assign io_in = {presc, dir, hold, mode, rst_n, clk};

   logic_demo_dut_wrapper_unused_guard u_guard_dummy_never ();

   logisim_demo_top dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_cycle  = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got 0x%02h, expected 0x%02h", name, n_cycle, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   int m_p;      // clocks seen while not held, modulo 8
   int m_cnt;    // counter value 0..255
   int m_lfsr;   // LFSR value
   int m_phase;  // dot position within its 14-step cycle

   function automatic void model_reset();
      m_p     = 0;
      m_cnt   = 0;
      m_lfsr  = 1;
      m_phase = 0;
   endfunction

   function automatic void model_clock(input logic h, input logic d, input logic [1:0] ps);
      int  period;
      bit  tick;
      int  fb;
      if (h) return;
      period = 1 << ps;
      tick   = (m_p % period) == (period - 1);
      m_p    = (m_p + 1) % 8;
      if (tick) begin
         m_cnt   = d ? (m_cnt + 255) % 256 : (m_cnt + 1) % 256;
         fb      = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
         m_lfsr  = ((m_lfsr << 1) & 255) | fb;
         m_phase = (m_phase + 1) % 14;
      end
   endfunction

   function automatic logic [7:0] model_out(input logic [1:0] md);
      int v;
      case (md)
         2'd0: v = m_cnt;
         2'd1: v = m_cnt ^ (m_cnt >> 1);
`ifdef LOGISIM_DEMO_LFSR_EN
         2'd2: v = m_lfsr;
`else
         2'd2: v = m_cnt;
`endif
         default: v = (m_phase <= 7) ? (1 << m_phase) : (1 << (14 - m_phase));
      endcase
      return v[7:0];
   endfunction

   logic [7:0] exp_q[$];

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge clk or negedge rst_n);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", io_out, e);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   // Drive one set of pins on the falling edge and queue the output expected
   // after the following rising edge.
   task automatic step(input logic r, input logic [1:0] m, input logic h,
                       input logic d, input logic [1:0] ps);
      @(negedge clk);
      n_cycle++;
      mode  = m;
      hold  = h;
      dir   = d;
      presc = ps;
      rst_n = r;
      if (!r) model_reset();
      else    model_clock(h, d, ps);
      exp_q.push_back(model_out(m));
   endtask

   task automatic steps(input int n, input logic [1:0] m, input logic h,
                        input logic d, input logic [1:0] ps);
      for (int i = 0; i < n; i++) step(1'b1, m, h, d, ps);
   endtask

   // Short reset pulse between clock edges; optionally check the output while
   // reset is still low against a fixed value.
   task automatic pulse(input bit anchor, input logic [7:0] anchor_val);
      @(posedge clk);
      #4;
      model_reset();
      exp_q.push_back(model_out(mode));
      rst_n = 1'b0;
      #2;
      if (anchor) check("reset_immediate", io_out, anchor_val);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic anchor(input string name, input logic [7:0] exp);
      @(posedge clk);
      #2;
      check(name, io_out, exp);
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      model_reset();
      step(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
      step(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
      anchor("reset_value", 8'h00);

      // Up count and wrap through 0x00.
      steps(5, 2'b00, 1'b0, 1'b0, 2'b00);
      anchor("count_5", 8'h05);
      steps(255, 2'b00, 1'b0, 1'b0, 2'b00);
      anchor("count_wrap", 8'h04);

      // Down count from reset.
      pulse(1'b1, 8'h00);
      steps(1, 2'b00, 1'b0, 1'b1, 2'b00);
      anchor("down_1", 8'hFF);
      steps(1, 2'b00, 1'b0, 1'b1, 2'b00);
      anchor("down_2", 8'hFE);

      // Gray after 3 up counts.
      pulse(1'b1, 8'h00);
      steps(3, 2'b01, 1'b0, 1'b0, 2'b00);
      anchor("gray_3", 8'h02);

      // LFSR mode.
      steps(1, 2'b10, 1'b0, 1'b0, 2'b00);
`ifdef LOGISIM_DEMO_LFSR_EN
      pulse(1'b1, 8'h01);
      steps(4, 2'b10, 1'b0, 1'b0, 2'b00);
      anchor("lfsr_4", 8'h11);
`else
      pulse(1'b1, 8'h00);
      steps(4, 2'b10, 1'b0, 1'b0, 2'b00);
      anchor("lfsr_off_4", 8'h04);
`endif

      // Bouncing dot.
      steps(1, 2'b11, 1'b0, 1'b0, 2'b00);
      pulse(1'b1, 8'h01);
      steps(7, 2'b11, 1'b0, 1'b0, 2'b00);
      anchor("dot_7", 8'h80);
      steps(1, 2'b11, 1'b0, 1'b0, 2'b00);
      anchor("dot_8", 8'h40);
      steps(6, 2'b11, 1'b0, 1'b0, 2'b00);
      anchor("dot_14", 8'h01);
      steps(1, 2'b11, 1'b0, 1'b0, 2'b00);
      anchor("dot_15", 8'h02);

      // Prescale /8 and hold.
      steps(1, 2'b00, 1'b0, 1'b0, 2'b11);
      pulse(1'b1, 8'h00);
      steps(7, 2'b00, 1'b0, 1'b0, 2'b11);
      anchor("presc_7", 8'h00);
      steps(1, 2'b00, 1'b0, 1'b0, 2'b11);
      anchor("presc_8", 8'h01);
      steps(8, 2'b00, 1'b0, 1'b0, 2'b11);
      anchor("presc_16", 8'h02);
      steps(20, 2'b00, 1'b1, 1'b0, 2'b11);
      anchor("hold_20", 8'h02);

      // Mid-run reset, then resume.
      pulse(1'b1, 8'h00);
      steps(55, 2'b00, 1'b0, 1'b0, 2'b00);
      anchor("count_37", 8'h37);
      pulse(1'b1, 8'h00);
      steps(3, 2'b00, 1'b0, 1'b0, 2'b00);
      anchor("resume_3", 8'h03);

      // Randomised run: all pins change freely, occasional reset pulses.
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] m;
         logic       h;
         logic       d;
         logic [1:0] ps;
         m  = 2'($urandom_range(0, 3));
         h  = ($urandom_range(0, 7) == 0);
         d  = 1'($urandom_range(0, 1));
         ps = 2'($urandom_range(0, 3));
         step(1'b1, m, h, d, ps);
         if ($urandom_range(0, 199) == 0) pulse(1'b0, 8'h00);
      end

      repeat (2) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// Empty helper so the bench elaborates as a single self-contained file even if
// nothing else is instantiated alongside the design.
module logic_demo_dut_wrapper_unused_guard;
endmodule
